risc_mem_ctrl: RTL
==================

# risc_mem_ctrl

Parametrised memory-access controller for the next-generation RISC processor. It sits between the processor's address/data/write-enable outputs and a variable-latency memory, and converts single-cycle processor accesses into a request/acknowledge transaction. It adds configurable minimum wait states, an acknowledge timeout with a sticky bus error, and a stall output that freezes the control unit. It also counts completed accesses.

## Interface
Parameters:
- DATA_W, 16, data bus width
- ADDR_W, 16, address width
- MIN_WAIT, 1, cycles in ACCESS before mem_ack is honoured (0..TIMEOUT-1)
- TIMEOUT, 15, cycles in ACCESS without accepted ack before abort (> MIN_WAIT)

Ports:
- Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  access request, sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  registered read data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_stall  out  1  freeze request to control unit
- err_clr  in  1  clears bus_err
- bus_err  out  1  sticky timeout flag
- acc_cnt  out  16  completed-access counter, wraps
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  latched address
- mem_dout  out  DATA_W  latched write data
- mem_din  in  DATA_W  memory read data
- mem_ack  in  1  memory acknowledge

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if cpu_req, latch cpu_addr, cpu_wdata and cpu_we, clear wait counter, and go to ACCESS.
- ACCESS:
  - mem_en=1; mem_we=latched we; mem_addr/mem_dout drive latched values.
  - The counter increments every cycle.
  - If cnt ≥ MIN_WAIT and mem_ack: on a read, cpu_rdata ← mem_din; on a write, cpu_rdata is unchanged. Go to DONE.
  - Else if cnt == TIMEOUT-1: set bus_err, cpu_rdata ← all ones, go to DONE.
- DONE: mem_en=0, mem_we=0, cpu_ready=1, acc_cnt += 1 (errors included), then always go to IDLE.
- A mem_ack seen while cnt < MIN_WAIT is ignored.
- cpu_* input changes during ACCESS/DONE are ignored because the values are latched.
- If cpu_req drops mid-access, the access still completes and cpu_ready still pulses.
- cpu_stall = (IDLE & cpu_req) | ACCESS, combinational.
- bus_err: err_clr clears it. If a timeout and err_clr occur in the same cycle, the flag is set.
- acc_cnt wraps 0xFFFF → 0x0000.

## Timing
- Reset values: state IDLE; mem_en, mem_we, cpu_ready, bus_err = 0; cpu_rdata, mem_addr, mem_dout, acc_cnt = 0.
- Reset in any state returns the block to IDLE at that edge, so mem_en is low the next cycle.
- Latency: cpu_req sampled at edge 0 → ACCESS from cycle 1 → cpu_ready at cycle MIN_WAIT+2 if ack is already high.
- Timeout: cpu_ready at cycle TIMEOUT+1.
- Back-to-back accesses have one mandatory IDLE cycle between the DONE cycle and the next ACCESS.
- cpu_rdata is valid from the cpu_ready cycle and holds until the next completed read.

## Structure
- Shared package `risc_pkg`: the state enum (IDLE/ACCESS/DONE) and default DATA_W/ADDR_W constants shared with the execution and control units.
- Single module; the wait counter stays inline, with width $clog2(TIMEOUT+1). No sub-module.
- Elaboration check: TIMEOUT > MIN_WAIT.

## Test plan
- Reset, then read of addr 0x0010 with MIN_WAIT=1 and ack held high, mem_din=0xBEEF → cpu_ready at cycle 3, cpu_rdata=0xBEEF, acc_cnt=1, bus_err=0.
- Write of 0xA5A5 to 0x0020 with ack arriving at cnt=4 → mem_we high cycles 1–5, mem_dout=0xA5A5, ready at cycle 6, cpu_rdata unchanged.
- No ack, TIMEOUT=15 → ready at cycle 16, cpu_rdata=0xFFFF, bus_err=1. Then err_clr together with a second timeout → bus_err stays 1; err_clr alone → 0.
- Ack pulse at cnt=0 only with MIN_WAIT=2 → ignored; ack at cnt=3 accepted, ready at cycle 5.
- Reset asserted mid-ACCESS (cycle 2) → mem_en=0 and state IDLE at cycle 3, acc_cnt=0, no cpu_ready.
- Preload acc_cnt=0xFFFF via 65535 accesses (or force) plus one more → wraps to 0x0000. Back-to-back requests show exactly one IDLE cycle between accesses.

Source files
------------

// File: rtl/risc_pkg.sv
// Types and constants shared by the RISC execution, control and memory-access units.
// Holds the memory controller state encoding and the default bus widths.
package risc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int ACC_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/risc_mem_ctrl.sv
// Memory-access controller: turns single-cycle CPU accesses into a req/ack memory
// transaction with minimum wait states, ack timeout (sticky bus_err) and CPU stall.
module risc_mem_ctrl
    import risc_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0]    cpu_wdata,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 cpu_ready,
    output logic                 cpu_stall,
    input  logic                 err_clr,
    output logic                 bus_err,
    output logic [ACC_CNT_W-1:0] acc_cnt,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_dout,
    input  logic [DATA_W-1:0]    mem_din,
    input  logic                 mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MIN_WAIT_C = CNT_W'(MIN_WAIT);
    localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

    if (TIMEOUT <= MIN_WAIT) begin : g_param_check
        $error("risc_mem_ctrl: TIMEOUT must be greater than MIN_WAIT");
    end

    mem_state_e             state_r;
    mem_state_e             state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic                   we_r;
    logic [ADDR_W-1:0]      addr_r;
    logic [DATA_W-1:0]      wdata_r;
    logic [DATA_W-1:0]      rdata_r;
    logic                   err_r;
    logic [ACC_CNT_W-1:0]   acc_cnt_r;
    logic [ACC_CNT_W-1:0]   acc_cnt_nxt_s;
    logic                   ack_ok_s;
    logic                   tmo_s;

    // Ack is only honoured once the minimum wait has elapsed; timeout loses to a same-cycle ack.
    assign ack_ok_s = (state_r == ACCESS) && (cnt_r >= MIN_WAIT_C) && mem_ack;
    assign tmo_s    = (state_r == ACCESS) && !ack_ok_s && (cnt_r == LAST_C);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cpu_req) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (ack_ok_s || tmo_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode; outputs depend only on registered state except the IDLE stall term.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_ready = 1'b0;
        cpu_stall = 1'b0;
        case (state_r)
            IDLE: begin
                cpu_stall = cpu_req;
            end
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = we_r;
                cpu_stall = 1'b1;
            end
            DONE: begin
                cpu_ready = 1'b1;
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase
    end

    // Request latch, wait counter and read-data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= '0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_req) begin
                        we_r    <= cpu_we;
                        addr_r  <= cpu_addr;
                        wdata_r <= cpu_wdata;
                        cnt_r   <= '0;
                    end
                end
                ACCESS: begin
                    cnt_r <= cnt_r + CNT_ONE_C;
                    if (ack_ok_s) begin
                        if (!we_r) begin
                            rdata_r <= mem_din;
                        end
                    end else if (tmo_s) begin
                        rdata_r <= '1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Sticky bus error: a timeout wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (tmo_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end
    end

    // Completed-access count, including timed-out accesses; wraps naturally.
    always_comb begin
        acc_cnt_nxt_s = acc_cnt_r;
        if (state_r == DONE) begin
            acc_cnt_nxt_s = acc_cnt_r + 16'd1;
        end else begin
            acc_cnt_nxt_s = acc_cnt_r;
        end
    end

    // Access counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt_r <= '0;
        end else begin
            acc_cnt_r <= acc_cnt_nxt_s;
        end
    end

    assign cpu_rdata = rdata_r;
    assign bus_err   = err_r;
    assign acc_cnt   = acc_cnt_r;
    assign mem_addr  = addr_r;
    assign mem_dout  = wdata_r;

endmodule
